// File: rtl/ct_f_spsram_req_ctrl.sv
`default_nettype none
// ===========================================================================
// ct_f_spsram_req_ctrl : valid/ready request controller with zero-fill for a
// single-port SRAM (active-low CEN/GWEN/WEN, 1-cycle Q).  Rev 1.0
// ===========================================================================
module ct_f_spsram_req_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 88,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_INIT = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] init_cnt_nxt;
  logic                  rsp_vld_nxt;
  logic                  accept;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= ST_BOOT;
      init_cnt <= '0;
      rsp_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      rsp_vld  <= rsp_vld_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    rsp_vld_nxt  = rsp_vld;
    accept       = 1'b0;
    init_done    = 1'b0;
    req_rdy      = 1'b0;
    sram_cen     = 1'b1;
    sram_gwen    = 1'b1;
    sram_wen     = '1;
    sram_a       = '0;
    sram_d       = '0;

    case (state)
      ST_BOOT: begin
        state_nxt = INIT_EN ? ST_INIT : ST_IDLE;
      end

      ST_INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt;
        if (init_cnt == LAST_ADDR) begin
          state_nxt    = ST_IDLE;
          init_cnt_nxt = '0;
        end else begin
          init_cnt_nxt = init_cnt + 1'b1;
        end
      end

      ST_IDLE: begin
        init_done = 1'b1;
        // A stalled response blocks new accesses so the SRAM keeps Q stable.
        req_rdy   = !rsp_vld || rsp_rdy;
        accept    = req_vld && req_rdy;
        if (accept) begin
          sram_cen = 1'b0;
          sram_a   = req_addr;
          if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_bmask;
            sram_d    = req_wdata;
          end
        end
        if (accept && !req_wr) begin
          rsp_vld_nxt = 1'b1;
        end else if (rsp_vld && rsp_rdy) begin
          rsp_vld_nxt = 1'b0;
        end
        if (init_req && !rsp_vld && !accept) begin
          state_nxt = ST_INIT;
        end
      end

      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  assign rsp_rdata = sram_q;

endmodule
`default_nettype wire
